// File: rtl/uart_byte_receiver_pkg.sv
// Shared UART definitions: receive FSM encoding, oversampling geometry and the
// default baud divider for a 50 MHz system clock at 115200 baud.
package uart_byte_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int TI_W       = $clog2(OVERSAMPLE);

  localparam logic [TI_W-1:0] SAMPLE_A = TI_W'(7);
  localparam logic [TI_W-1:0] SAMPLE_B = TI_W'(8);
  localparam logic [TI_W-1:0] SAMPLE_C = TI_W'(9);
  localparam logic [TI_W-1:0] TI_LAST  = TI_W'(OVERSAMPLE - 1);

  // 50e6 / (115200 * 16) rounds to 27
  localparam int DEFAULT_CLKS_PER_TICK = 27;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick divider: counts 0..DIVISOR-1 while enabled and flags the
// terminal count. Shared between the UART receive and transmit paths.
module uart_tick_gen #(
  parameter int DIVISOR = 27
) (
  input  logic clock,
  input  logic reset_uart,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(DIVISOR - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (!reset_uart || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= (count_reg == TERMINAL) ? '0 : count_reg + 1'b1;
    end
  end

  assign tick = enable && (count_reg == TERMINAL);

endmodule

// File: rtl/uart_byte_receiver.sv
// 16x-oversampled UART receive engine: synchronizes rxd, votes 2-of-3 around
// mid-bit and delivers bytes with one-cycle valid / framing-error strobes.
module uart_byte_receiver
  import uart_byte_receiver_pkg::*;
#(
  parameter int CLKS_PER_TICK = DEFAULT_CLKS_PER_TICK,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clock,
  input  logic                 reset_uart,
  input  logic                 enable_uart,
  input  logic                 enable_rx,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_indicator
);

  localparam logic [2:0] BC_LAST = 3'(DATA_BITS - 1);

  logic                 sync_meta_reg;
  logic                 rxs_reg;
  rx_state_t            state_reg;
  logic [TI_W-1:0]      ti_reg;
  logic [2:0]           bc_reg;
  logic                 samp_a_reg;
  logic                 samp_b_reg;
  logic                 bit_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] r_data_reg;
  logic                 rx_valid_reg;
  logic                 frame_err_reg;
  logic                 rx_indicator_reg;

  logic rx_enabled;
  logic tick;
  logic vote;

  assign rx_enabled = enable_uart & enable_rx;
  assign vote       = majority3(samp_a_reg, samp_b_reg, rxs_reg);

  always_ff @(posedge clock) begin
    if (!reset_uart) begin
      sync_meta_reg <= 1'b1;
      rxs_reg       <= 1'b1;
    end else begin
      sync_meta_reg <= rxd;
      rxs_reg       <= sync_meta_reg;
    end
  end

  // Divider sits at zero in IDLE so the first tick lands CLKS_PER_TICK after detect
  uart_tick_gen #(
    .DIVISOR(CLKS_PER_TICK)
  ) u_tick_gen (
    .clock      (clock),
    .reset_uart (reset_uart),
    .clear      (!rx_enabled || (state_reg == ST_IDLE)),
    .enable     (rx_enabled),
    .tick       (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset_uart) begin
      state_reg        <= ST_IDLE;
      ti_reg           <= '0;
      bc_reg           <= '0;
      samp_a_reg       <= 1'b1;
      samp_b_reg       <= 1'b1;
      bit_reg          <= 1'b1;
      shift_reg        <= '0;
      r_data_reg       <= '0;
      rx_valid_reg     <= 1'b0;
      frame_err_reg    <= 1'b0;
      rx_indicator_reg <= 1'b0;
    end else begin
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      if (!rx_enabled) begin
        state_reg        <= ST_IDLE;
        ti_reg           <= '0;
        bc_reg           <= '0;
        shift_reg        <= '0;
        rx_indicator_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (!rxs_reg) begin
              state_reg        <= ST_START;
              ti_reg           <= '0;
              bc_reg           <= '0;
              shift_reg        <= '0;
              rx_indicator_reg <= 1'b1;
            end
          end
          ST_BREAK: begin
            if (rxs_reg) begin
              state_reg        <= ST_IDLE;
              rx_indicator_reg <= 1'b0;
            end
          end
          default: begin
            if (tick) begin
              ti_reg <= ti_reg + 1'b1;
              if (ti_reg == SAMPLE_A) samp_a_reg <= rxs_reg;
              if (ti_reg == SAMPLE_B) samp_b_reg <= rxs_reg;
              case (state_reg)
                ST_START: begin
                  if (ti_reg == SAMPLE_C && vote) begin
                    state_reg        <= ST_IDLE;
                    rx_indicator_reg <= 1'b0;
                  end else if (ti_reg == TI_LAST) begin
                    state_reg <= ST_DATA;
                  end
                end
                ST_DATA: begin
                  if (ti_reg == SAMPLE_C) bit_reg <= vote;
                  if (ti_reg == TI_LAST) begin
                    shift_reg[bc_reg] <= bit_reg;
                    if (bc_reg == BC_LAST) begin
                      state_reg <= ST_STOP;
                      bc_reg    <= '0;
                    end else begin
                      bc_reg <= bc_reg + 1'b1;
                    end
                  end
                end
                ST_STOP: begin
                  // Deciding mid-stop-bit leaves half a bit of slack to re-sync
                  if (ti_reg == SAMPLE_C) begin
                    if (vote) begin
                      r_data_reg       <= shift_reg;
                      rx_valid_reg     <= 1'b1;
                      state_reg        <= ST_IDLE;
                      rx_indicator_reg <= 1'b0;
                    end else begin
                      frame_err_reg <= 1'b1;
                      state_reg     <= ST_BREAK;
                    end
                  end
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign r_data       = r_data_reg;
  assign rx_valid     = rx_valid_reg;
  assign frame_err    = frame_err_reg;
  assign rx_indicator = rx_indicator_reg;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver: frames are serialized onto rxd and the
// expected pulses are queued, then matched against DUT strobes as they appear.
module tb_uart_byte_receiver;

  localparam int CPT      = 4;
  localparam int BIT_CLKS = 16 * CPT;
  // detect lands 2..3 clocks after the rxd fall, pulse 154 ticks after detect
  localparam int LAT_MIN  = 2 + 154 * CPT;
  localparam int LAT_MAX  = 3 + 154 * CPT;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         start_cyc;
  } exp_t;

  logic       clock;
  logic       reset_uart;
  logic       enable_uart;
  logic       enable_rx;
  logic       rxd;
  logic [7:0] r_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_indicator;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] last_good;

  uart_byte_receiver #(
    .CLKS_PER_TICK(CPT),
    .DATA_BITS    (8)
  ) dut (
    .clock       (clock),
    .reset_uart  (reset_uart),
    .enable_uart (enable_uart),
    .enable_rx   (enable_rx),
    .rxd         (rxd),
    .r_data      (r_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .rx_indicator(rx_indicator)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    idle(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_val);
    exp_t e;
    e.is_err    = ~stop_val;
    e.data      = stop_val ? data : last_good;
    e.start_cyc = cyc;
    sb.push_back(e);
    if (stop_val) last_good = data;
    $display("send data=%02h stop=%0b expect=%s", data, stop_val, stop_val ? "valid" : "frame_err");
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop_val);
  endtask

  // Pulse monitor: pops the scoreboard on every strobe
  always @(negedge clock) begin
    if (rx_valid === 1'b1 || frame_err === 1'b1) begin
      check("pulse_exclusive", 32'(rx_valid & frame_err), 32'd0);
      check("pulse_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        int   lat;
        e   = sb.pop_front();
        lat = cyc - e.start_cyc;
        $display("pulse valid=%0b err=%0b r_data=%02h latency=%0d", rx_valid, frame_err, r_data, lat);
        check("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
        check("pulse_r_data", 32'(r_data), 32'(e.data));
        total++;
        assert (lat >= LAT_MIN && lat <= LAT_MAX)
        else begin
          bad++;
          $error("FAIL pulse_latency observed=%0d expected=%0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
      end
    end
  end

  initial begin
    int gstart;
    rxd         = 1'b1;
    enable_uart = 1'b1;
    enable_rx   = 1'b1;
    reset_uart  = 1'b0;
    last_good   = 8'h00;

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_r_data", 32'(r_data), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_indicator", 32'(rx_indicator), 32'd0);
    @(posedge clock);
    #1 reset_uart = 1'b1;
    idle(20);

    // framing error, line held low, then a good frame
    send_frame(8'h3C, 1'b0);
    rxd = 1'b0;
    idle(200);
    @(negedge clock);
    check("break_indicator_high", 32'(rx_indicator), 32'd1);
    check("break_r_data_held", 32'(r_data), 32'd0);
    @(posedge clock);
    #1 rxd = 1'b1;
    idle(BIT_CLKS);
    @(negedge clock);
    check("break_exit_indicator", 32'(rx_indicator), 32'd0);
    @(posedge clock);
    #1;
    send_frame(8'h3C, 1'b1);
    idle(40);

    // plain 0xA5
    send_frame(8'hA5, 1'b1);
    idle(40);

    // start-bit glitch of 16 clocks
    gstart = cyc;
    rxd = 1'b0;
    idle(10);
    @(negedge clock);
    check("glitch_indicator_high", 32'(rx_indicator), 32'd1);
    @(posedge clock);
    #1;
    idle(5);
    rxd = 1'b1;
    idle(44 - (cyc - gstart));
    @(negedge clock);
    $display("glitch check at delta=%0d indicator=%0b", cyc - gstart, rx_indicator);
    check("glitch_indicator_low", 32'(rx_indicator), 32'd0);
    check("glitch_r_data", 32'(r_data), 32'(last_good));
    @(posedge clock);
    #1;
    idle(40);

    // back-to-back frames with no idle bits
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(40);

    // receiver disabled during bit 4 of 0x81
    rxd = 1'b0;
    idle(BIT_CLKS);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rxd = 1'b0;
    idle(BIT_CLKS / 2);
    enable_rx = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("disable_indicator", 32'(rx_indicator), 32'd0);
    check("disable_r_data", 32'(r_data), 32'(last_good));
    @(posedge clock);
    #1 rxd = 1'b1;
    idle(20);
    enable_rx = 1'b1;
    idle(BIT_CLKS);
    send_frame(8'h42, 1'b1);
    idle(40);

    // one-clock reset in the middle of 0x99
    rxd = 1'b0;
    idle(BIT_CLKS);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    reset_uart = 1'b0;
    @(posedge clock);
    #1;
    reset_uart = 1'b1;
    rxd        = 1'b1;
    last_good  = 8'h00;
    @(negedge clock);
    check("midreset_r_data", 32'(r_data), 32'd0);
    check("midreset_indicator", 32'(rx_indicator), 32'd0);
    check("midreset_rx_valid", 32'(rx_valid), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    @(posedge clock);
    #1;
    idle(BIT_CLKS);
    send_frame(8'h5A, 1'b1);
    idle(40);

    check("all_pulses_seen", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_receiver.md
# uart_byte_receiver

Standalone 16x-oversampled UART receive engine: it turns the serial `rxd` line into parallel bytes with a one-cycle valid strobe and a framing-error strobe. It is the receive-side counterpart of the existing UART transmit path. It sits between the pad-side `rxd` input and the byte consumer (CPU/DDS control registers). It generates its own oversample tick from the system clock, so no external baud clock is needed.

## Interface
- `CLKS_PER_TICK`, default 27: system clocks per oversample tick. 50 MHz / (115200*16) ≈ 27. Legal range ≥ 2.
- `DATA_BITS`, default 8: data bits per frame, LSB first. Legal range 5..8.
- `clock`  in  1  system clock, rising edge.
- `reset_uart`  in  1  synchronous, active-low reset.
- `enable_uart`  in  1  global UART enable; low behaves as `enable_rx` low.
- `enable_rx`  in  1  receiver enable.
- `rxd`  in  1  asynchronous serial input, idle high.
- `r_data`  out  DATA_BITS  last good byte; changes only on a good frame.
- `rx_valid`  out  1  one-cycle pulse; `r_data` is new in the same cycle.
- `frame_err`  out  1  one-cycle pulse; stop bit sampled low.
- `rx_indicator`  out  1  high while a frame is in progress (any state except IDLE).

## Operation
- `rxd` passes through a 2-FF synchronizer; the receiver sees only the synchronized `rxs`. The synchronizer flops reset to 1.
- Tick divider: counts 0..CLKS_PER_TICK-1 and pulses `tick` on the terminal count. It is held at 0 in IDLE and starts counting in the cycle a start edge is detected.
- Per-bit tick index `ti` runs 0..15. Samples are taken at `ti` = 7, 8 and 9, and the 2-of-3 majority gives the bit value.
- States:
  - IDLE: `rxs`=0 → START, with `ti` and the bit counter cleared.
  - START: majority is decided at `ti`=9.
    - If 1 (glitch) → IDLE, with no pulse.
    - Otherwise wait to `ti`=15, then → DATA.
  - DATA: shift the majority into bit `bc` at `ti`=15, LSB first. After bit DATA_BITS-1 → STOP.
  - STOP: decide at `ti`=9.
    - If 1: load `r_data`, pulse `rx_valid`, → IDLE. The early exit allows re-sync on back-to-back frames.
    - If 0: pulse `frame_err`, leave `r_data` unchanged, → BREAK.
  - BREAK: wait for `rxs`=1, then → IDLE.
- `enable_rx`=0 or `enable_uart`=0 forces IDLE on the next edge.
  - The divider and shift register are cleared.
  - `r_data` is held; no pulses are issued.
  - A frame that is in progress is discarded.
- `rx_valid` and `frame_err` never assert in the same cycle.

## Timing
- Reset values:
  - `r_data`=0, `rx_valid`=0, `frame_err`=0, `rx_indicator`=0.
  - State is IDLE.
  - Synchronizer flops are 1.
- Start detect: the edge where `rxs` is first seen low is 2–3 clocks after the `rxd` fall.
- Let T0 be the detect edge. `rx_valid`/`frame_err` are registered on the edge of tick number 16*(DATA_BITS+1)+9, counting ticks from 0. With DATA_BITS=8 that is tick 153, which is (154*CLKS_PER_TICK) clocks after T0. The pulses are visible for exactly the following cycle.
- `rx_indicator` rises the cycle after T0 and falls together with the state returning to IDLE.
- Reset or disable mid-frame: the abort takes effect within 1 clock, and no partial data reaches `r_data`.
- A new start bit is accepted in the first IDLE cycle after the STOP decision. The minimum inter-frame gap is 0 idle bits.

## Structure
- The shared UART package holds:
  - the state encoding (IDLE/START/DATA/STOP/BREAK);
  - `OVERSAMPLE`=16 and the sample indices 7/8/9;
  - the default `CLKS_PER_TICK` for 50 MHz/115200.
- One sub-module, `uart_tick_gen`: a parameterized divider with a synchronous clear and enable. It is reusable by the transmit path.
- The majority vote and the FSM stay in this module.

## Test plan
All scenarios use CLKS_PER_TICK=4, so 1 bit = 64 clocks.
1. Send 0xA5 (8N1) → one `rx_valid` pulse at T0+616 clocks, `r_data`=0xA5, `frame_err` never high.
2. Hold `rxd` low for 16 clocks, then high → no `rx_valid`, no `frame_err`, `rx_indicator` returns low before T0+44.
3. Send 0x3C with the stop bit driven low, hold low 200 clocks, then idle and send 0x3C correctly → first frame: `frame_err` pulse with `r_data` still 0; second frame: `rx_valid` with 0x3C.
4. Send 0x00 then 0xFF back-to-back with zero idle bits → two `rx_valid` pulses, `r_data` 0x00 then 0xFF.
5. Drop `enable_rx` during bit 4 of 0x81, re-enable, send 0x42 → no pulse for the aborted frame; `rx_valid` with 0x42.
6. Assert `reset_uart`=0 for 1 clock mid-frame → all outputs return to reset values next cycle; a following frame 0x5A is received correctly.
